// File: rtl/bitcount_dispatch_if.sv
// Valid/ready stream bundle for bitcount_dispatch: input word stream and result stream.
// slave = the dispatcher side, master = the producer/consumer side.
interface bitcount_dispatch_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bitcount_dispatch.sv
// Stream front-end for the bitcount core: input FIFO, one-word-in-flight dispatch, ordered results.
// Optional WAIT timeout enabled by defining BITCOUNT_DISPATCH_TIMEOUT_EN.
module bitcount_dispatch #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitcount_dispatch_if.slave   bus,
  output logic                 core_start,
  output logic [WIDTH-1:0]     core_in,
  input  logic                 core_finish,
  input  logic [WIDTH-1:0]     core_count,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             core_start_q, core_start_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             finish_q;
  logic [WIDTH-1:0] core_in_q, core_in_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             push, pop, capture, tmo;

  assign push    = bus.in_valid && in_ready_q;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  // Only a fresh rising edge counts; a level left over from the previous word is ignored.
  assign capture = (state_q == S_WAIT) && core_finish && !finish_q;

`ifdef BITCOUNT_DISPATCH_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  logic [TmrW-1:0] timer_q, timer_d;
  logic            err_q, err_d;

  assign tmo = (state_q == S_WAIT) && !capture && (timer_q == TmrW'(TIMEOUT - 1));

  always_comb begin
    timer_d = timer_q;
    err_d   = err_q;
    if (state_q == S_START)     timer_d = '0;
    else if (state_q == S_WAIT) timer_d = timer_q + TmrW'(1);
    if (tmo) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (capture || tmo) state_d = S_OUT;
      S_OUT:   if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead so every port comes from a flop
  always_comb begin
    core_start_d = (state_d == S_START);
    out_valid_d  = (state_d == S_OUT);
    core_in_d    = core_in_q;
    out_data_d   = out_data_q;
    if (pop) core_in_d = mem_q[rd_ptr_q];
    if (capture)  out_data_d = core_count;
    else if (tmo) out_data_d = '1;
  end

  // FIFO bookkeeping; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != CntW'(DEPTH));
    busy_d     = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b1;
      core_in_q    <= '0;
      out_data_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      core_start_q <= core_start_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      finish_q     <= core_finish;
      core_in_q    <= core_in_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign core_start    = core_start_q;
  assign core_in       = core_in_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_bitcount_dispatch.sv
// Self-checking bench for bitcount_dispatch: behavioural core model plus in-order scoreboard.
module tb_bitcount_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_start, core_finish, busy, err_timeout;
  logic [31:0] core_in, core_count;

  bitcount_dispatch_if #(.WIDTH(32)) bus ();

  bitcount_dispatch #(.WIDTH(32), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .core_start  (core_start),
    .core_in     (core_in),
    .core_finish (core_finish),
    .core_count  (core_count),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_in_q[$];
  logic [31:0] exp_out_q[$];

  int  lat, drop_dly;
  bit  nofinish, rnd_core, rnd_rdy;
  int  hs_cyc, start_cyc, fin_cyc, ov_cyc, n_starts = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Core model: popcount after a latency, finish held high until dropped after the next start
  initial begin : core_model
    logic [31:0] m_word;
    int m_cnt, m_lat, m_drop;
    bit m_active;
    m_active = 0; m_cnt = 0; m_lat = 0; m_drop = 0; m_word = '0;
    core_finish = 1'b0;
    core_count  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) m_active = 0;
      else if (core_start) begin
        m_word = core_in; m_cnt = 0; m_active = 1;
        m_lat  = rnd_core ? int'($urandom_range(3, 40)) : lat;
        m_drop = rnd_core ? int'($urandom_range(1, m_lat - 1)) : drop_dly;
      end else if (m_active) begin
        m_cnt++;
        if (m_cnt == m_drop) core_finish = 1'b0;
        if (!nofinish && m_cnt == m_lat) begin
          core_finish = 1'b1;
          core_count  = 32'($countones(m_word));
          fin_cyc     = cyc;
          m_active    = 0;
        end
      end
    end
  end

  // Monitor / scoreboard, sampled mid-cycle after inputs settle
  initial begin : monitor
    bit prev_start, prev_ov;
    prev_start = 0; prev_ov = 0;
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        if (core_start) begin
          n_starts++;
          start_cyc = cyc;
          check("start_pulse_width", 32'(prev_start), 32'd0);
          if (exp_in_q.size() == 0) check("start_spurious", 32'd1, 32'd0);
          else check("core_in", core_in, exp_in_q.pop_front());
        end
        if (bus.out_valid && !prev_ov) ov_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_out_q.size() == 0) check("out_spurious", 32'd1, 32'd0);
          else check("out_data", bus.out_data, exp_out_q.pop_front());
        end
        prev_start = core_start;
        prev_ov    = bus.out_valid;
      end else begin
        prev_start = 0;
        prev_ov    = 0;
      end
    end
  end

  initial begin : rdy_driver
    forever begin
      @(negedge clk);
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at a negedge; returns at a negedge after the word is accepted
  task automatic push(input logic [31:0] w, input logic [31:0] e);
    bit done;
    done = 0;
    exp_in_q.push_back(w);
    exp_out_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 400 && !done; i++) begin
      done = bus.in_ready;
      if (done) hs_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #2;
      ok = (exp_out_q.size() == 0) && !busy;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin : main
    int s0;
    bit seen;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    lat = 10; drop_dly = 1; nofinish = 0; rnd_core = 0; rnd_rdy = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single word with the latency contract
    lat = 33;
    push(32'h8000_0000, 32'd1);
    wait_idle(300);
    check("start_latency", 32'(start_cyc - hs_cyc), 32'd2);
    check("out_latency", 32'(ov_cyc - fin_cyc), 32'd1);

    // Burst fills the FIFO
    push(32'h0000_0000, 32'd0);
    push(32'h8000_0000, 32'd1);
    push(32'h8000_0800, 32'd2);
    push(32'h8408_0804, 32'd5);
    push(32'h9010_C83C, 32'd10);
    check("burst_full_in_ready", 32'(bus.in_ready), 32'd0);
    check("burst_busy", 32'(busy), 32'd1);
    wait_idle(1000);

    // Backpressure holds the result and blocks further dispatch
    lat = 10;
    bus.out_ready = 1'b0;
    push(32'hF852_4A22, 32'd13);
    push(32'h0000_0001, 32'd1);
    push(32'h0000_0003, 32'd2);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      seen = bus.out_valid;
    end
    check("bp_out_valid_seen", 32'(seen), 32'd1);
    s0 = n_starts;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_data", bus.out_data, 32'd13);
    end
    check("bp_no_start", 32'(n_starts - s0), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    wait_idle(500);

    // Stale finish from the previous word must not be captured
    lat = 10; drop_dly = 1;
    push(32'h8408_0804, 32'd5);
    wait_idle(300);
    check("stale_prev_finish_high", 32'(core_finish), 32'd1);
    lat = 12; drop_dly = 3;
    push(32'hFF00_FF00, 32'd16);
    wait_idle(300);
    drop_dly = 1;

`ifdef BITCOUNT_DISPATCH_TIMEOUT_EN
    nofinish = 1;
    push(32'h1234_5678, 32'hFFFF_FFFF);
    wait_idle(400);
    check("tmo_latency", 32'(ov_cyc - start_cyc), 32'd65);
    check("tmo_err", 32'(err_timeout), 32'd1);
    nofinish = 0;
    lat = 20;
    push(32'hFFFF_FFFF, 32'd32);
    wait_idle(300);
    check("tmo_err_sticky", 32'(err_timeout), 32'd1);
`else
    check("err_tied_low", 32'(err_timeout), 32'd0);
`endif

    // Randomized traffic with random core latency and consumer stalls
    rnd_core = 1; rnd_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (i % 7 == 0) w = w & $urandom;
      push(w, 32'($countones(w)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(5000);
    rnd_core = 0; rnd_rdy = 0;
    bus.out_ready = 1'b1;

    // Reset while a word is in WAIT and three more are queued
    lat = 40;
    s0 = n_starts;
    push(32'h0000_000F, 32'd4);
    push(32'h0000_00FF, 32'd8);
    push(32'h0000_0FFF, 32'd12);
    push(32'h0000_FFFF, 32'd16);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #2;
      seen = (n_starts != s0);
    end
    check("rst_test_started", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_in_q.delete();
    exp_out_q.delete();
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_core_start", 32'(core_start), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err_timeout), 32'd0);
    check("mid_rst_core_in", core_in, 32'd0);
    check("mid_rst_out_data", bus.out_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = n_starts;
    @(negedge clk);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("rel_no_start", 32'(n_starts - s0), 32'd0);
    lat = 5;
    push(32'h00FF_00FF, 32'd16);
    wait_idle(300);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bitcount_dispatch.md
# bitcount_dispatch

Stream front-end wrapped around the `bitcount` core, sitting directly upstream and downstream of it. It accepts 32-bit words on a valid/ready input stream and buffers them in a small FIFO. It issues one `start` pulse per word to the core, holds the core input stable, and detects the core's `finish` rising edge. Each count is returned in order on a valid/ready output stream.

## Interface
- `WIDTH`, 32: data and count width.
- `DEPTH`, 4: input FIFO entries; power of two, at least 2.
- `TIMEOUT`, 64: WAIT-state cycle limit; used only with the timeout feature.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word offered.
- `in_ready`  out  1  FIFO can accept a word.
- `in_data`  in  WIDTH  word to count.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_in`  out  WIDTH  word under count; stable from START until the capture cycle.
- `core_finish`  in  1  core done level; may stay high until the next start.
- `core_count`  in  WIDTH  core result; valid while `core_finish` is high.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  result.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.
- `err_timeout`  out  1  sticky timeout flag.

## Operation
- FIFO push: when `in_valid && in_ready`. `in_ready = !full`, registered-state based. A pop in the same cycle does not raise `in_ready` while full.
- **IDLE**: if FIFO is not empty, pop the head into `core_in` and go to START. If empty, stay in IDLE.
- **START**: `core_start=1` for exactly one cycle. Clear the wait timer. Go to WAIT.
- **WAIT**:
  - `finish_q` registers `core_finish` every cycle.
  - Capture fires on `core_finish && !finish_q` only. A finish level held over from the previous word is ignored until it falls and rises again.
  - On capture: `out_data <= core_count`, go to OUT.
- **OUT**: `out_valid=1`. `out_data` stays stable until `out_ready`. On handshake, go to IDLE.
- Results leave in input order. Only one word is in flight at a time.
- `core_in` holds its value after capture, until the next pop.

## Timing
- Reset (`rst_n` low, asynchronous):
  - FSM goes to IDLE and the FIFO is flushed.
  - `in_ready`, `core_start`, `out_valid`, `busy`, `err_timeout` = 0.
  - `core_in` and `out_data` = 0.
  - `finish_q` resets to 1, so a core finish still held high never counts as a rising edge.
- First cycle after reset release: `in_ready=1`.
- Latency for an empty FIFO in IDLE:
  - Handshake at cycle N.
  - Pop at N+1.
  - `core_start` high at N+2.
  - WAIT entered at N+3.
  - A finish edge sampled at cycle F gives `out_valid` at F+1.
- Push and pop in the same cycle: occupancy is unchanged.
- Push into an empty FIFO: the pop happens the following cycle, never the same cycle.
- Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- Reset mid-operation drops the queued words and the in-flight word. This block does not reset the core.

## Configuration
- Macro: `BITCOUNT_DISPATCH_TIMEOUT_EN`.
- Defined:
  - The WAIT timer counts cycles spent in WAIT.
  - When the timer reaches TIMEOUT without a capture: `out_data <= {WIDTH{1'b1}}`, `err_timeout <= 1` (sticky until reset), go to OUT.
  - Any later finish edge from that word is ignored.
- Undefined: WAIT lasts indefinitely, the timer is absent, and `err_timeout` is tied to 0.

## Test plan
- Single word: `in_data=0x80000000`; core model raises finish 33 cycles after start with count 1 -> exactly one `core_start` cycle with `core_in=0x80000000`, then `out_valid=1`, `out_data=1`.
- Burst: words 0x00000000, 0x80000000, 0x80000800, 0x84080804, 0x9010C83C offered back-to-back with `out_ready=1` -> `in_ready` low while 4 words are queued; outputs 0, 1, 2, 5, 10 in order.
- Backpressure: result 13 (word 0xF8524A22) with `out_ready=0` for 50 cycles -> `out_valid` and `out_data=13` held stable, no new `core_start` while queued words wait.
- Stale finish: core holds finish high from the previous word, then lowers it 3 cycles after the new start and raises it with count 16 (word 0xFF00FF00) -> capture occurs only on the new rising edge; the result is 16, not the previous count.
- Timeout (macro defined, TIMEOUT=64): core never finishes -> after 64 WAIT cycles `out_data=0xFFFFFFFF` and `err_timeout=1`. The next word, 0xFFFFFFFF, returns 32 and `err_timeout` stays 1.
- Reset mid-WAIT with 3 words queued -> all outputs 0 during reset; `in_ready=1`, `busy=0`, and no `core_start` after release; a new word 0x00FF00FF returns 16.
